// File: rtl/cva6_mem_tid_alloc_if.sv
// Handshake bundle between the dcache miss path, the response path and the TID allocator.
// Signal suffixes are from the allocator's point of view (slave modport).
interface cva6_mem_tid_alloc_if #(
    parameter int unsigned TID_W = 0
);
    // A zero-width TID still needs a 1-bit carrier, which is tied to 0.
    localparam int unsigned IdxW = (TID_W > 0) ? TID_W : 1;

    logic            clear_i;
    logic            alloc_req_i;
    logic            alloc_gnt_o;
    logic [IdxW-1:0] alloc_tid_o;
    logic            free_valid_i;
    logic [IdxW-1:0] free_tid_i;
    logic [TID_W:0]  outstanding_o;
    logic            full_o;
    logic            empty_o;
    logic            err_o;

    modport slave (
        input  clear_i, alloc_req_i, free_valid_i, free_tid_i,
        output alloc_gnt_o, alloc_tid_o, outstanding_o, full_o, empty_o, err_o
    );

    modport master (
        output clear_i, alloc_req_i, free_valid_i, free_tid_i,
        input  alloc_gnt_o, alloc_tid_o, outstanding_o, full_o, empty_o, err_o
    );
endinterface

// File: rtl/cva6_mem_tid_alloc.sv
// Memory transaction-ID pool for dcache miss/refill traffic: lowest-free allocation,
// retire on final response beat, occupancy count and sticky error on bad frees.
package config_pkg;
    typedef struct packed {
        int unsigned MEM_TID_WIDTH;
        int unsigned DCACHE_MAX_TX;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{MEM_TID_WIDTH: 32'd0, DCACHE_MAX_TX: 32'd1};
endpackage

module cva6_mem_tid_alloc
    import config_pkg::*;
#(
    parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    cva6_mem_tid_alloc_if.slave      bus
);
    localparam int unsigned NumTx = CVA6Cfg.DCACHE_MAX_TX;
    localparam int unsigned TidW  = CVA6Cfg.MEM_TID_WIDTH;
    localparam int unsigned IdxW  = (TidW > 0) ? TidW : 1;
    localparam logic [TidW:0] NumTxC = (TidW + 1)'(NumTx);

    logic [NumTx-1:0] busy_q, busy_d;
    logic [TidW:0]    cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [IdxW-1:0]  first_free;
    logic [IdxW-1:0]  free_tid;
    logic [NumTx-1:0] gnt_oh, free_oh;
    logic             full, gnt, free_hit, free_ok, free_bad;

    assign full     = (cnt_q == NumTxC);
    assign free_tid = (TidW == 0) ? '0 : bus.free_tid_i;

    // Priority scan from the top so the lowest free index wins; only registered
    // state feeds the grant, so a same-cycle free can never be re-granted.
    always_comb begin
        first_free = '0;
        for (int i = int'(NumTx) - 1; i >= 0; i--) begin
            if (!busy_q[i]) first_free = IdxW'(i);
        end
    end

    always_comb begin
        gnt_oh  = '0;
        free_oh = '0;
        for (int i = 0; i < int'(NumTx); i++) begin
            gnt_oh[i]  = (first_free == IdxW'(i));
            free_oh[i] = (free_tid == IdxW'(i));
        end
    end

    assign gnt      = bus.alloc_req_i & ~full & ~bus.clear_i;
    assign free_hit = |(busy_q & free_oh);
    assign free_ok  = bus.free_valid_i & free_hit;
    assign free_bad = bus.free_valid_i & ~free_hit;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        err_d  = err_q | free_bad;
        if (gnt)     busy_d = busy_d | gnt_oh;
        if (free_ok) busy_d = busy_d & ~free_oh;
        unique case ({gnt, free_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (bus.clear_i) begin
            busy_d = '0;
            cnt_d  = '0;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign bus.alloc_gnt_o   = gnt;
    assign bus.alloc_tid_o   = full ? '0 : first_free;
    assign bus.outstanding_o = cnt_q;
    assign bus.full_o        = full;
    assign bus.empty_o       = (cnt_q == '0);
    assign bus.err_o         = err_q;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (cnt_q <= NumTxC)
                else $error("tid alloc: count exceeds pool size");
            assert (!(gnt && |(busy_q & gnt_oh)))
                else $error("tid alloc: granted a busy TID");
        end
    end
`endif
endmodule

// File: tb/tb_cva6_mem_tid_alloc.sv
// Bench for cva6_mem_tid_alloc with a 4-entry pool: directed scenarios plus a
// random alloc/free stream, both checked through a per-cycle expectation queue.
module tb_cva6_mem_tid_alloc;
    localparam config_pkg::cva6_cfg_t Cfg = '{MEM_TID_WIDTH: 32'd2, DCACHE_MAX_TX: 32'd4};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cva6_mem_tid_alloc_if #(.TID_W(2)) bus ();

    cva6_mem_tid_alloc #(.CVA6Cfg(Cfg)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        bit         gnt;
        logic [1:0] tid;
        logic [3:0] busy;
        int         cnt;
        bit         err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model of the pool, advanced once per driven cycle.
    logic [3:0] m_busy = '0;
    int         m_cnt  = 0;
    bit         m_err  = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.alloc_gnt_o !== e.gnt) begin
                errors++; $display("FAIL sb_gnt: got %0b want %0b", bus.alloc_gnt_o, e.gnt);
            end
            if (e.gnt) begin
                checks++;
                if (bus.alloc_tid_o !== e.tid) begin
                    errors++; $display("FAIL sb_tid: got %0d want %0d", bus.alloc_tid_o, e.tid);
                end
                checks++;
                if (bus.alloc_gnt_o === 1'b1 && e.busy[bus.alloc_tid_o] === 1'b1) begin
                    errors++; $display("FAIL sb_dup: tid %0d already live (busy=%b)", bus.alloc_tid_o, e.busy);
                end
            end
            checks++;
            if (bus.outstanding_o !== 3'(e.cnt)) begin
                errors++; $display("FAIL sb_outstanding: got %0d want %0d", bus.outstanding_o, e.cnt);
            end
            checks++;
            if (bus.full_o !== (e.cnt == 4) || bus.empty_o !== (e.cnt == 0)) begin
                errors++; $display("FAIL sb_full_empty: got %0b/%0b want cnt %0d", bus.full_o, bus.empty_o, e.cnt);
            end
            checks++;
            if (bus.err_o !== e.err) begin
                errors++; $display("FAIL sb_err: got %0b want %0b", bus.err_o, e.err);
            end
        end
    end

    // Drives one cycle starting at posedge+1, samples at the negedge, returns at next posedge+1.
    task automatic drive(input bit req, input bit fv, input logic [1:0] ftid, input bit clr,
                         output bit gnt, output logic [1:0] tid, output logic [2:0] outs);
        exp_t e;
        bit   hit;
        bus.alloc_req_i  = req;
        bus.free_valid_i = fv;
        bus.free_tid_i   = ftid;
        bus.clear_i      = clr;
        e.tid = 2'd0;
        for (int i = 3; i >= 0; i--) if (!m_busy[i]) e.tid = 2'(i);
        e.gnt  = req && !clr && (m_cnt < 4);
        e.busy = m_busy;
        e.cnt  = m_cnt;
        e.err  = m_err;
        sb.push_back(e);
        @(negedge clk);
        gnt  = bus.alloc_gnt_o;
        tid  = bus.alloc_tid_o;
        outs = bus.outstanding_o;
        if (clr) begin
            m_busy = '0; m_cnt = 0; m_err = 1'b0;
        end else begin
            hit = fv && m_busy[ftid];
            if (fv && !hit) m_err = 1'b1;
            if (hit) begin m_busy[ftid] = 1'b0; m_cnt--; end
            if (e.gnt) begin m_busy[e.tid] = 1'b1; m_cnt++; end
        end
        @(posedge clk);
        #1;
        bus.alloc_req_i  = 1'b0;
        bus.free_valid_i = 1'b0;
        bus.clear_i      = 1'b0;
    endtask

    task automatic test_reset();
        bus.alloc_req_i = 1'b0; bus.free_valid_i = 1'b0; bus.free_tid_i = '0; bus.clear_i = 1'b0;
        #12;
        checks++;
        if (bus.alloc_gnt_o !== 1'b0 || bus.alloc_tid_o !== 2'd0) begin
            errors++; $display("FAIL reset_gnt: got gnt %0b tid %0d want 0/0", bus.alloc_gnt_o, bus.alloc_tid_o);
        end
        checks++;
        if (bus.outstanding_o !== 3'd0 || bus.full_o !== 1'b0 || bus.empty_o !== 1'b1 || bus.err_o !== 1'b0) begin
            errors++; $display("FAIL reset_status: got outs %0d full %0b empty %0b err %0b want 0/0/1/0",
                               bus.outstanding_o, bus.full_o, bus.empty_o, bus.err_o);
        end
        bus.alloc_req_i = 1'b1;
        #1;
        checks++;
        if (bus.alloc_gnt_o !== 1'b1) begin
            errors++; $display("FAIL reset_req_gnt: got %0b want 1", bus.alloc_gnt_o);
        end
        bus.alloc_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        bit g; logic [1:0] t; logic [2:0] o;
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0, g, t, o);
            checks++;
            if (g !== 1'b1 || t !== 2'(k)) begin
                errors++; $display("FAIL fill_tid%0d: got gnt %0b tid %0d want 1/%0d", k, g, t, k);
            end
        end
        drive(1, 0, 0, 0, g, t, o);
        checks++;
        if (g !== 1'b0 || o !== 3'd4 || bus.full_o !== 1'b1) begin
            errors++; $display("FAIL fill_full: got gnt %0b outs %0d full %0b want 0/4/1", g, o, bus.full_o);
        end
    endtask

    task automatic test_full_free();
        bit g; logic [1:0] t; logic [2:0] o;
        drive(1, 1, 2, 0, g, t, o);
        checks++;
        if (g !== 1'b0) begin
            errors++; $display("FAIL full_free_nogrant: got %0b want 0", g);
        end
        drive(1, 0, 0, 0, g, t, o);
        checks++;
        if (g !== 1'b1 || t !== 2'd2) begin
            errors++; $display("FAIL full_free_regrant: got gnt %0b tid %0d want 1/2", g, t);
        end
        drive(0, 0, 0, 0, g, t, o);
        checks++;
        if (o !== 3'd4) begin
            errors++; $display("FAIL full_free_outs: got %0d want 4", o);
        end
    endtask

    task automatic test_clear();
        bit g; logic [1:0] t; logic [2:0] o;
        drive(1, 1, 1, 1, g, t, o);
        checks++;
        if (g !== 1'b0) begin
            errors++; $display("FAIL clear_gnt: got %0b want 0", g);
        end
        drive(0, 0, 0, 0, g, t, o);
        checks++;
        if (o !== 3'd0 || bus.empty_o !== 1'b1) begin
            errors++; $display("FAIL clear_outs: got %0d empty %0b want 0/1", o, bus.empty_o);
        end
    endtask

    task automatic test_simul();
        bit g; logic [1:0] t; logic [2:0] o;
        drive(1, 0, 0, 0, g, t, o);
        drive(1, 0, 0, 0, g, t, o);
        drive(1, 1, 0, 0, g, t, o);
        checks++;
        if (g !== 1'b1 || t !== 2'd2) begin
            errors++; $display("FAIL simul_tid: got gnt %0b tid %0d want 1/2", g, t);
        end
        drive(0, 0, 0, 0, g, t, o);
        checks++;
        if (o !== 3'd2) begin
            errors++; $display("FAIL simul_outs: got %0d want 2", o);
        end
        drive(1, 0, 0, 0, g, t, o);
        checks++;
        if (g !== 1'b1 || t !== 2'd0) begin
            errors++; $display("FAIL simul_reuse: got gnt %0b tid %0d want 1/0", g, t);
        end
        drive(0, 0, 0, 1, g, t, o);
    endtask

    task automatic test_err();
        bit g; logic [1:0] t; logic [2:0] o;
        drive(0, 1, 3, 0, g, t, o);
        checks++;
        if (bus.err_o !== 1'b1 || bus.outstanding_o !== 3'd0 || bus.empty_o !== 1'b1) begin
            errors++; $display("FAIL err_set: got err %0b outs %0d empty %0b want 1/0/1",
                               bus.err_o, bus.outstanding_o, bus.empty_o);
        end
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, g, t, o);
        checks++;
        if (bus.err_o !== 1'b1) begin
            errors++; $display("FAIL err_sticky: got %0b want 1", bus.err_o);
        end
        drive(0, 0, 0, 1, g, t, o);
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++; $display("FAIL err_clear: got %0b want 0", bus.err_o);
        end
    endtask

    task automatic test_async_reset();
        bit g; logic [1:0] t; logic [2:0] o;
        drive(0, 1, 3, 0, g, t, o);
        for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, g, t, o);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.outstanding_o !== 3'd0 || bus.empty_o !== 1'b1 || bus.err_o !== 1'b0) begin
            errors++; $display("FAIL async_reset: got outs %0d empty %0b err %0b want 0/1/0",
                               bus.outstanding_o, bus.empty_o, bus.err_o);
        end
        m_busy = '0; m_cnt = 0; m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, g, t, o);
        checks++;
        if (g !== 1'b1 || t !== 2'd0) begin
            errors++; $display("FAIL async_first_tid: got gnt %0b tid %0d want 1/0", g, t);
        end
    endtask

    task automatic test_random();
        bit g; logic [1:0] t; logic [2:0] o;
        bit req = 1'b0;
        bit fv, clr;
        logic [1:0] ftid;
        for (int n = 0; n < 10000; n++) begin
            if (!req) req = ($urandom_range(0, 1) == 1);
            fv   = ($urandom_range(0, 2) == 0);
            ftid = 2'($urandom_range(0, 3));
            // Mostly retire live IDs; a few deliberate bad frees exercise the error path.
            if (fv && m_busy != '0 && $urandom_range(0, 19) != 0) begin
                while (!m_busy[ftid]) ftid = 2'($urandom_range(0, 3));
            end
            clr = ($urandom_range(0, 996) == 0);
            drive(req, fv, ftid, clr, g, t, o);
            if (g) req = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_free();
        test_clear();
        test_simul();
        test_err();
        test_async_reset();
        test_random();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
